// File: rtl/fetch_imem_if.sv
// ---------------------------------------------------------------------------
// fetch_imem_if
//   Request/response bus between the fetch controller and instruction memory.
//   One request may be outstanding; a request is accepted on the cycle
//   imem_req && imem_gnt, and the matching response arrives later as a
//   single-cycle imem_rvalid pulse carrying imem_rdata.
//
//   Signals:
//     imem_req    fetch -> mem   request valid
//     imem_addr   fetch -> mem   request address (the fetch PC)
//     imem_gnt    mem -> fetch   request accepted this cycle
//     imem_rvalid mem -> fetch   response valid (one-cycle pulse)
//     imem_rdata  mem -> fetch   response instruction
//
//   Modports: master (fetch controller side), slave (memory side).
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_imem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//   Instruction-fetch sequencer. Owns the fetch PC, issues one outstanding
//   request at a time to instruction memory and places each returned
//   instruction into a registered IF output toward decode. Decode
//   backpressure (stall_i) is absorbed by a one-entry skid buffer, and EX
//   redirects flush the IF output and discard any response still in flight.
//
//   Ports:
//     clk            in   rising-edge clock
//     reset          in   synchronous, active-high reset
//     redirect_en    in   EX redirect (taken branch / jump) this cycle
//     redirect_addr  in   redirect target
//     stall_i        in   decode cannot accept; IF output must hold
//     imem           if   fetch_imem_if.master (req/addr out, gnt/rvalid/rdata in)
//     if_valid       out  IF output holds a valid instruction
//     if_pc          out  PC of if_instr
//     if_instr       out  fetched instruction
//     fetch_fault    out  misaligned-redirect pulse (0 without the option)
//
//   Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//     defined   - a redirect whose target has nonzero low two bits loads
//                 TRAP_ADDR into the PC and pulses fetch_fault for one cycle.
//     undefined - the low two bits of redirect_addr are masked to zero and
//                 fetch_fault is tied low.
//
//   Best case is one instruction every two cycles: a FETCH cycle for the
//   grant followed by a WAIT cycle for a 1-cycle-latency response.
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_controller #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  stall_i,
  fetch_imem_if.master          imem,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  fetch_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;     // PC of the outstanding request
  logic                  req_q;        // registered imem_req
  logic                  discard_q;    // outstanding response belongs to a flushed path
  logic                  ifv_q;
  logic [ADDR_WIDTH-1:0] if_pc_q;
  logic [DATA_WIDTH-1:0] if_instr_q;
  // Skid buffer: occupied exactly while the FSM sits in HOLD, so it needs
  // no separate valid flag; leaving HOLD (consume or flush) empties it.
  logic [ADDR_WIDTH-1:0] skid_pc_q;
  logic [DATA_WIDTH-1:0] skid_instr_q;

  logic [ADDR_WIDTH-1:0] redir_pc_d;   // PC to load on a redirect
  logic [ADDR_WIDTH-1:0] pc_inc_d;
  logic                  grant_d;
  logic                  out_free_d;   // IF output can take new data this cycle

  assign pc_inc_d   = pc_q + ADDR_WIDTH'(4);
  assign grant_d    = req_q && imem.imem_gnt;
  assign out_free_d = !ifv_q || !stall_i;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_d;
  logic fault_q;

  assign fault_d    = redirect_en && (redirect_addr[1:0] != 2'b00);
  assign redir_pc_d = fault_d ? TRAP_ADDR : redirect_addr;

  // Fault pulse is registered: visible the cycle after the redirect only.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_misalign;

  assign redir_pc_d      = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
  assign fetch_fault     = 1'b0;
  assign unused_misalign = ^{TRAP_ADDR, redirect_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
      ifv_q      <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else if (redirect_en) begin
      // Redirect wins over everything else, including a stalled output.
      pc_q  <= redir_pc_d;
      ifv_q <= 1'b0;
      case (state_q)
        WAIT: begin
          if (imem.imem_rvalid) begin
            // The stale response lands this very cycle: drop it and go.
            discard_q <= 1'b0;
            state_q   <= FETCH;
            req_q     <= 1'b1;
          end else begin
            discard_q <= 1'b1;
            state_q   <= WAIT;
            req_q     <= 1'b0;
          end
        end
        FETCH: begin
          if (grant_d) begin
            // Memory already accepted the old address; its response is
            // still owed and must be thrown away.
            discard_q <= 1'b1;
            state_q   <= WAIT;
            req_q     <= 1'b0;
          end else begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end else begin
      // Output handshake; a load below overrides this clear.
      if (ifv_q && !stall_i) begin
        ifv_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (grant_d) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_inc_d;
            state_q  <= WAIT;
            req_q    <= 1'b0;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= FETCH;
              req_q     <= 1'b1;
            end else if (out_free_d) begin
              if_pc_q    <= req_pc_q;
              if_instr_q <= imem.imem_rdata;
              ifv_q      <= 1'b1;
              state_q    <= FETCH;
              req_q      <= 1'b1;
            end else begin
              skid_pc_q    <= req_pc_q;
              skid_instr_q <= imem.imem_rdata;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          // Output is full and stalled here; once decode takes it, the
          // skid entry replaces it without a bubble.
          if (!stall_i) begin
            if_pc_q    <= skid_pc_q;
            if_instr_q <= skid_instr_q;
            ifv_q      <= 1'b1;
            state_q    <= FETCH;
            req_q      <= 1'b1;
          end
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign if_valid       = ifv_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

endmodule

`default_nettype wire
